// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and data width
// Used by the receiver and the transmitter so both agree on the encoding.
package uart_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - metastability synchroniser for the rx pad
// Ports:
//   clk_50m  in  system clock
//   rst_n    in  asynchronous active-low reset (chain resets to idle-high)
//   rx       in  asynchronous serial input
//   rx_s     out synchronised serial input, STAGES clocks of latency
module uart_rx_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_50m,
   input  logic rst_n,
   input  logic rx,
   output logic rx_s
);

   logic [STAGES-1:0] chain;

   // Reset to 1s so a reset never looks like a start bit.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '1;
      end else begin
         chain <= {chain[STAGES-2:0], rx};
      end
   end

   assign rx_s = chain[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with 16x oversampling and rdy/rdy_clr handshake
// Ports:
//   clk_50m    in   system clock
//   rst_n      in   asynchronous active-low reset
//   clken      in   one-cycle tick at OVERSAMPLE x baud
//   rx         in   serial input, idle high, asynchronous
//   rdy_clr    in   consumer has taken dout; clears rdy, frame_err, overrun
//   dout       out  last correctly framed byte
//   rdy        out  dout holds an unconsumed byte
//   frame_err  out  sticky, stop bit sampled low
//   overrun    out  sticky, byte completed while rdy was still set
//   rx_busy    out  receiver is not idle
module uart_receiver
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   input  logic              clken,
   input  logic              rx,
   input  logic              rdy_clr,
   output logic [DATA_W-1:0] dout,
   output logic              rdy,
   output logic              frame_err,
   output logic              overrun,
   output logic              rx_busy
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

   logic rx_s;

   uart_rx_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .rx      (rx),
      .rx_s    (rx_s)
   );

   uart_state_t       state,     state_nxt;
   logic [CNT_W-1:0]  cnt,       cnt_nxt;
   logic [BIT_W-1:0]  bitpos,    bitpos_nxt;
   logic [DATA_W-1:0] shift,     shift_nxt;
   logic [DATA_W-1:0] dout_nxt;
   logic              armed,     armed_nxt;
   logic              rdy_nxt,   fe_nxt,    ov_nxt;

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bitpos    <= '0;
         shift     <= '0;
         armed     <= 1'b0;
         dout      <= '0;
         rdy       <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bitpos    <= bitpos_nxt;
         shift     <= shift_nxt;
         armed     <= armed_nxt;
         dout      <= dout_nxt;
         rdy       <= rdy_nxt;
         frame_err <= fe_nxt;
         overrun   <= ov_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      bitpos_nxt = bitpos;
      shift_nxt  = shift;
      armed_nxt  = armed;
      dout_nxt   = dout;
      rdy_nxt    = rdy;
      fe_nxt     = frame_err;
      ov_nxt     = overrun;

      // Consumer clear first; a simultaneous frame completion below overrides it.
      if (rdy_clr) begin
         rdy_nxt = 1'b0;
         fe_nxt  = 1'b0;
         ov_nxt  = 1'b0;
      end

      case (state)
         ST_IDLE: begin
            // armed guarantees a high-to-low edge, so a held-low line
            // (break) cannot retrigger reception.
            if (rx_s) begin
               armed_nxt = 1'b1;
            end
            if (clken && armed && !rx_s) begin
               state_nxt = ST_START;
               cnt_nxt   = '0;
            end
         end

         ST_START: begin
            if (clken) begin
               if (cnt == CNT_MID) begin
                  if (!rx_s) begin
                     state_nxt  = ST_DATA;
                     cnt_nxt    = '0;
                     bitpos_nxt = '0;
                  end else begin
                     state_nxt  = ST_IDLE;
                  end
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
         end

         ST_DATA: begin
            if (clken) begin
               if (cnt == CNT_LAST) begin
                  shift_nxt[bitpos] = rx_s;
                  cnt_nxt           = '0;
                  if (bitpos == BIT_LAST) begin
                     state_nxt = ST_STOP;
                  end else begin
                     bitpos_nxt = bitpos + BIT_ONE;
                  end
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
         end

         ST_STOP: begin
            if (clken) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = ST_IDLE;
                  armed_nxt = 1'b0;
                  cnt_nxt   = '0;
                  if (rx_s) begin
                     dout_nxt = shift;
                     rdy_nxt  = 1'b1;
                     // A byte that was being taken this same cycle is not lost.
                     if (rdy && !rdy_clr) begin
                        ov_nxt = 1'b1;
                     end
                  end else begin
                     fe_nxt = 1'b1;
                  end
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign rx_busy = (state != ST_IDLE);

endmodule
